// File: rtl/mp3_ctrl_pkg.sv
// Shared types, index constants and seven-segment helpers for the MP3 transport controller.
package mp3_ctrl_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_PLAY, ST_PAUSE} state_t;

  // Arbitrated transport event; declaration order is the priority order.
  typedef enum logic [2:0] {EV_NONE, EV_STOP, EV_DONE, EV_NEXT, EV_PREV, EV_PLAY} ev_t;

  typedef struct packed {
    logic [3:0] min_t;
    logic [3:0] min_o;
    logic [3:0] sec_t;
    logic [3:0] sec_o;
  } bcd_time_t;

  localparam int NUM_BTN       = 4;
  localparam int BTN_PLAY      = 0;
  localparam int BTN_STOP      = 1;
  localparam int BTN_NEXT      = 2;
  localparam int BTN_PREV      = 3;

  localparam int SW_REPEAT_ALL = 0;
  localparam int SW_DISP       = 1;
  localparam int SW_REPEAT_ONE = 2;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return SEG_BLANK;
    endcase
  endfunction

  // One-second BCD increment, saturating at 99:59.
  function automatic bcd_time_t bcd_inc(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t == 16'h9959) return t;
    if (t.sec_o != 4'd9) r.sec_o = t.sec_o + 4'd1;
    else begin
      r.sec_o = 4'd0;
      if (t.sec_t != 4'd5) r.sec_t = t.sec_t + 4'd1;
      else begin
        r.sec_t = 4'd0;
        if (t.min_o != 4'd9) r.min_o = t.min_o + 4'd1;
        else begin
          r.min_o = 4'd0;
          r.min_t = t.min_t + 4'd1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mp3_transport_ctrl_if.sv
// Decoder-side handshake: track load request/ack, end-of-track pulse and run enable.
interface mp3_transport_ctrl_if #(
  parameter int TRACK_W = 7
) ();
  logic               load_req;
  logic [TRACK_W-1:0] load_track;
  logic               load_ack;
  logic               track_done;
  logic               playing;

  modport master (output load_req, load_track, playing, input load_ack, track_done);
  modport slave  (input load_req, load_track, playing, output load_ack, track_done);
endinterface

// File: rtl/button_debounce.sv
// Per-key 2-FF synchronizer, debounce counter and one-cycle press pulse (active-low key).
module button_debounce #(
  parameter int DB_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_n,
  output logic press
);
  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic [1:0]       sync;
  logic             level;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // cnt counts consecutive samples that disagree with the accepted level.
  assign accept = (sync[1] != level) && (cnt == CNT_W'(DB_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], raw_n};
      press <= 1'b0;
      if (sync[1] == level) cnt <= '0;
      else if (accept) begin
        level <= sync[1];
        cnt   <= '0;
        press <= ~sync[1];
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/mp3_transport_ctrl.sv
// Transport FSM, elapsed-time keeping and seven-segment display for the MP3 player.
module mp3_transport_ctrl
  import mp3_ctrl_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int DEBOUNCE_MS = 20,
  parameter int NUM_TRACKS  = 8,
  parameter int TRACK_W     = 7
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [3:0]  buttons_export,
  input  logic [2:0]  switchs_export,
  output logic [27:0] seven_seg_export,
  mp3_transport_ctrl_if.master dec
);
  localparam int DB_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int PRESC_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [TRACK_W-1:0] LAST = TRACK_W'(NUM_TRACKS - 1);

  logic [NUM_BTN-1:0] press;
  logic [2:0]         sw_meta, sw;

  state_t             state, state_nxt;
  ev_t                ev;
  logic [TRACK_W-1:0] track, track_nxt, trk_inc, trk_dec;
  logic               stop_pend, pend_nxt, time_clr, past3, tick;
  logic [PRESC_W-1:0] presc;
  bcd_time_t          tm;
  logic [7:0]         t1;
  logic [27:0]        disp_nxt;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    button_debounce #(.DB_CYCLES(DB_CYCLES)) u_btn (
      .clk   (clk_clk),
      .rst_n (reset_reset_n),
      .raw_n (buttons_export[g]),
      .press (press[g])
    );
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) {sw, sw_meta} <= '0;
    else                {sw, sw_meta} <= {sw_meta, switchs_export};
  end

  always_comb begin
    ev = EV_NONE;
    if      (press[BTN_STOP]) ev = EV_STOP;
    else if (dec.track_done)  ev = EV_DONE;
    else if (press[BTN_NEXT]) ev = EV_NEXT;
    else if (press[BTN_PREV]) ev = EV_PREV;
    else if (press[BTN_PLAY]) ev = EV_PLAY;
  end

  assign trk_inc = (track == LAST) ? '0 : track + 1'b1;
  assign trk_dec = (track == '0) ? LAST : track - 1'b1;
  assign past3   = (tm.min_t != 4'd0) || (tm.min_o != 4'd0) || (tm.sec_t != 4'd0) ||
                   (tm.sec_o >= 4'd3);

  always_comb begin
    state_nxt = state;
    track_nxt = track;
    pend_nxt  = stop_pend;
    case (state)
      ST_IDLE: begin
        case (ev)
          EV_PLAY: state_nxt = ST_LOAD;
          EV_NEXT: track_nxt = trk_inc;
          EV_PREV: track_nxt = trk_dec;
          default: ;
        endcase
      end
      ST_LOAD: begin
        if (dec.load_ack) begin
          state_nxt = (stop_pend || ev == EV_STOP) ? ST_IDLE : ST_PLAY;
          pend_nxt  = 1'b0;
        end else if (ev == EV_STOP) pend_nxt = 1'b1;
      end
      default: begin
        case (ev)
          EV_PLAY: state_nxt = (state == ST_PLAY) ? ST_PAUSE : ST_PLAY;
          EV_STOP: state_nxt = ST_IDLE;
          EV_NEXT: begin
            state_nxt = ST_LOAD;
            track_nxt = trk_inc;
          end
          EV_PREV: begin
            state_nxt = ST_LOAD;
            track_nxt = past3 ? track : trk_dec;
          end
          EV_DONE: begin
            if (state == ST_PLAY) begin
              if (sw[SW_REPEAT_ONE]) state_nxt = ST_LOAD;
              else if (track == LAST && !sw[SW_REPEAT_ALL]) begin
                state_nxt = ST_IDLE;
                track_nxt = '0;
              end else begin
                state_nxt = ST_LOAD;
                track_nxt = trk_inc;
              end
            end
          end
          default: ;
        endcase
      end
    endcase
  end

  // Time restarts when a load is acknowledged and whenever playback falls back to IDLE.
  assign time_clr = (state == ST_LOAD && dec.load_ack) ||
                    (state != ST_IDLE && state_nxt == ST_IDLE);
  assign tick     = (state == ST_PLAY) && (presc == PRESC_W'(CLK_HZ - 1));

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state          <= ST_IDLE;
      track          <= '0;
      stop_pend      <= 1'b0;
      dec.load_req   <= 1'b0;
      dec.load_track <= '0;
      dec.playing    <= 1'b0;
    end else begin
      state        <= state_nxt;
      track        <= track_nxt;
      stop_pend    <= pend_nxt;
      dec.load_req <= (state_nxt == ST_LOAD);
      dec.playing  <= (state_nxt == ST_PLAY);
      if (state != ST_LOAD && state_nxt == ST_LOAD) dec.load_track <= track_nxt;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      presc <= '0;
      tm    <= '0;
    end else begin
      if (state_nxt == ST_LOAD || state_nxt == ST_IDLE) presc <= '0;
      else if (state == ST_PLAY) presc <= tick ? '0 : presc + 1'b1;
      if (time_clr)  tm <= '0;
      else if (tick) tm <= bcd_inc(tm);
    end
  end

  assign t1 = 8'(track) + 8'd1;

  always_comb begin
    disp_nxt = {seg7(tm.min_t), seg7(tm.min_o), seg7(tm.sec_t), seg7(tm.sec_o)};
    if (sw[SW_DISP])
      disp_nxt = {SEG_BLANK, SEG_BLANK,
                  (t1 < 8'd10) ? SEG_BLANK : seg7(4'(t1 / 8'd10)),
                  seg7(4'(t1 % 8'd10))};
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) seven_seg_export <= 28'hFFFFFFF;
    else                seven_seg_export <= disp_nxt;
  end
endmodule

// File: tb/tb_mp3_transport_ctrl.sv
// Self-checking bench: directed transport scenarios plus a randomized button/decoder walk
// checked against a transaction-level player model.
module tb_mp3_transport_ctrl;
  localparam int NT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  keys = 4'hF;
  logic [2:0]  sw = 3'b000;
  logic [27:0] seg;
  int          checks = 0;
  int          failures = 0;

  // model: 0 idle, 1 loading, 2 playing, 3 paused
  int m_state, m_track;
  bit m_pend;

  mp3_transport_ctrl_if #(.TRACK_W(7)) dec ();

  mp3_transport_ctrl #(.CLK_HZ(1000), .DEBOUNCE_MS(2), .NUM_TRACKS(NT), .TRACK_W(7)) dut (
    .clk_clk          (clk),
    .reset_reset_n    (rst_n),
    .buttons_export   (keys),
    .switchs_export   (sw),
    .seven_seg_export (seg),
    .dec              (dec)
  );

  always #5 clk = ~clk;

  initial begin
    #1200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  function automatic logic [6:0] dig(int d);
    logic [6:0] tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return tbl[d];
  endfunction

  function automatic logic [27:0] exp_time(int s);
    int m = s / 60, c = s % 60;
    return {dig(m / 10), dig(m % 10), dig(c / 10), dig(c % 10)};
  endfunction

  function automatic logic [27:0] exp_track(int t);
    int v = t + 1;
    return {7'h7F, 7'h7F, (v < 10) ? 7'h7F : dig(v / 10), dig(v % 10)};
  endfunction

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(logic [3:0] mask);
    keys = ~mask;
    step(6);
    keys = 4'hF;
    step(6);
  endtask

  task automatic pulse_ack();
    dec.load_ack = 1'b1;
    step(1);
    dec.load_ack = 1'b0;
    step(3);
  endtask

  task automatic pulse_done();
    dec.track_done = 1'b1;
    step(1);
    dec.track_done = 1'b0;
    step(3);
  endtask

  task automatic test_reset();
    dec.load_ack = 1'b0;
    dec.track_done = 1'b0;
    step(3);
    checks++;
    if (seg !== 28'hFFFFFFF) begin
      failures++; $display("FAIL reset_seg got=%h exp=FFFFFFF", seg);
    end
    checks++;
    if (dec.load_req !== 1'b0 || dec.playing !== 1'b0 || dec.load_track !== 7'd0) begin
      failures++;
      $display("FAIL reset_outs got req=%b play=%b trk=%0d exp 0/0/0",
               dec.load_req, dec.playing, dec.load_track);
    end
    rst_n = 1'b1;
    step(1);
    checks++;
    if (seg !== exp_time(0)) begin
      failures++; $display("FAIL reset_release_seg got=%h exp=%h", seg, exp_time(0));
    end
  endtask

  task automatic test_debounce_play();
    keys = 4'hE; step(1);
    keys = 4'hF; step(1);
    keys = 4'hE; step(5);
    keys = 4'hF; step(8);
    checks++;
    if (dec.load_req !== 1'b1 || dec.load_track !== 7'd0 || dec.playing !== 1'b0) begin
      failures++;
      $display("FAIL bounce_load got req=%b trk=%0d play=%b exp 1/0/0",
               dec.load_req, dec.load_track, dec.playing);
    end
    step(4);
    dec.load_ack = 1'b1;
    step(1);
    dec.load_ack = 1'b0;
    checks++;
    if (dec.load_req !== 1'b0) begin
      failures++; $display("FAIL ack_drop got req=%b exp=0", dec.load_req);
    end
    step(2);
    checks++;
    if (dec.playing !== 1'b1) begin
      failures++; $display("FAIL ack_play got=%b exp=1", dec.playing);
    end
    step(61300);
    checks++;
    if (seg !== exp_time(61)) begin
      failures++; $display("FAIL time_0101 got=%h exp=%h", seg, exp_time(61));
    end
  endtask

  task automatic test_prev();
    press(4'b1000);
    checks++;
    if (dec.load_req !== 1'b1 || dec.load_track !== 7'd0) begin
      failures++; $display("FAIL prev_restart got req=%b trk=%0d exp 1/0", dec.load_req, dec.load_track);
    end
    pulse_ack();
    checks++;
    if (seg !== exp_time(0) || dec.playing !== 1'b1) begin
      failures++; $display("FAIL restart_clear got seg=%h play=%b exp seg=%h play=1", seg, dec.playing, exp_time(0));
    end
    step(1500);
    checks++;
    if (seg !== exp_time(1)) begin
      failures++; $display("FAIL time_0001 got=%h exp=%h", seg, exp_time(1));
    end
    press(4'b1000);
    checks++;
    if (dec.load_req !== 1'b1 || dec.load_track !== 7'd7) begin
      failures++; $display("FAIL prev_wrap got req=%b trk=%0d exp 1/7", dec.load_req, dec.load_track);
    end
    pulse_ack();
    step(5500);
    checks++;
    if (seg !== exp_time(5)) begin
      failures++; $display("FAIL time_0005 got=%h exp=%h", seg, exp_time(5));
    end
    press(4'b1000);
    checks++;
    if (dec.load_req !== 1'b1 || dec.load_track !== 7'd7) begin
      failures++; $display("FAIL prev_same got req=%b trk=%0d exp 1/7", dec.load_req, dec.load_track);
    end
    pulse_ack();
    checks++;
    if (seg !== exp_time(0)) begin
      failures++; $display("FAIL prev_same_clear got=%h exp=%h", seg, exp_time(0));
    end
  endtask

  task automatic test_track_done();
    sw = 3'b000; step(4);
    pulse_done();
    checks++;
    if (dec.playing !== 1'b0 || dec.load_req !== 1'b0) begin
      failures++; $display("FAIL done_last_idle got play=%b req=%b exp 0/0", dec.playing, dec.load_req);
    end
    sw = 3'b010; step(4);
    checks++;
    if (seg !== exp_track(0)) begin
      failures++; $display("FAIL done_last_track got=%h exp=%h", seg, exp_track(0));
    end
    sw = 3'b001; step(4);
    press(4'b1000);
    press(4'b0001);
    pulse_ack();
    pulse_done();
    checks++;
    if (dec.load_req !== 1'b1 || dec.load_track !== 7'd0) begin
      failures++; $display("FAIL done_repeat_all got req=%b trk=%0d exp 1/0", dec.load_req, dec.load_track);
    end
    pulse_ack();
    sw = 3'b100; step(4);
    press(4'b1000);
    pulse_ack();
    pulse_done();
    checks++;
    if (dec.load_req !== 1'b1 || dec.load_track !== 7'd7) begin
      failures++; $display("FAIL done_repeat_one got req=%b trk=%0d exp 1/7", dec.load_req, dec.load_track);
    end
    pulse_ack();
  endtask

  task automatic test_load_stop();
    bit saw_play = 1'b0;
    sw = 3'b000; step(4);
    press(4'b0100);
    press(4'b0110);
    checks++;
    if (dec.load_req !== 1'b1 || dec.load_track !== 7'd0) begin
      failures++; $display("FAIL load_stop_hold got req=%b trk=%0d exp 1/0", dec.load_req, dec.load_track);
    end
    dec.load_ack = 1'b1;
    step(1);
    dec.load_ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (dec.playing !== 1'b0) saw_play = 1'b1;
      step(1);
    end
    checks++;
    if (saw_play || dec.load_req !== 1'b0) begin
      failures++; $display("FAIL load_stop_idle got play_seen=%b req=%b exp 0/0", saw_play, dec.load_req);
    end
  endtask

  task automatic test_pause_display();
    press(4'b0100);
    press(4'b0100);
    press(4'b0001);
    checks++;
    if (dec.load_track !== 7'd2) begin
      failures++; $display("FAIL pause_load_trk got=%0d exp=2", dec.load_track);
    end
    pulse_ack();
    step(7500);
    press(4'b0001);
    checks++;
    if (dec.playing !== 1'b0 || seg !== exp_time(7)) begin
      failures++; $display("FAIL pause_enter got play=%b seg=%h exp 0/%h", dec.playing, seg, exp_time(7));
    end
    step(5000);
    checks++;
    if (seg !== exp_time(7) || dec.load_req !== 1'b0) begin
      failures++; $display("FAIL pause_hold got seg=%h req=%b exp %h/0", seg, dec.load_req, exp_time(7));
    end
    sw = 3'b010; step(4);
    checks++;
    if (seg !== {7'h7F, 7'h7F, 7'h7F, 7'h30}) begin
      failures++; $display("FAIL track_disp got=%h exp=%h", seg, {7'h7F, 7'h7F, 7'h7F, 7'h30});
    end
    press(4'b0010);
  endtask

  task automatic test_random();
    int op;
    m_state = 0; m_track = 2; m_pend = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (m_state == 1) begin
        op = $urandom_range(0, 3);
        if (op <= 1) begin
          pulse_ack();
          m_state = m_pend ? 0 : 2;
          m_pend = 1'b0;
        end else if (op == 2) begin
          press(4'b0010);
          m_pend = 1'b1;
        end else press(4'b0100);
      end else begin
        sw = {1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1))};
        step(4);
        op = $urandom_range(0, 4);
        case (op)
          0: begin
            press(4'b0001);
            if (m_state == 0) m_state = 1;
            else m_state = (m_state == 2) ? 3 : 2;
          end
          1: begin
            press(4'b0010);
            m_state = 0;
          end
          2: begin
            press(4'b0100);
            m_track = (m_track + 1) % NT;
            if (m_state != 0) m_state = 1;
          end
          3: begin
            press(4'b1000);
            m_track = (m_track + NT - 1) % NT;
            if (m_state != 0) m_state = 1;
          end
          default: begin
            pulse_done();
            if (m_state == 2) begin
              if (sw[2]) m_state = 1;
              else if (m_track == NT - 1 && !sw[0]) begin
                m_state = 0; m_track = 0;
              end else begin
                m_state = 1; m_track = (m_track + 1) % NT;
              end
            end
          end
        endcase
      end
      checks++;
      if (dec.playing !== (m_state == 2) || dec.load_req !== (m_state == 1) ||
          (m_state == 1 && dec.load_track !== 7'(m_track)) || seg !== exp_track(m_track)) begin
        failures++;
        $display("FAIL rand_%0d got play=%b req=%b trk=%0d seg=%h exp state=%0d trk=%0d seg=%h",
                 i, dec.playing, dec.load_req, dec.load_track, seg, m_state, m_track, exp_track(m_track));
      end
    end
  endtask

  initial begin
    test_reset();
    test_debounce_play();
    test_prev();
    test_track_done();
    test_load_stop();
    test_pause_display();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mp3_transport_ctrl.md
Name: mp3_transport_ctrl

Overview:
Transport and display controller for the MP3 player system. It debounces the four board push-buttons and samples the three switches. A play/stop/pause/track FSM sequences the audio decoder through a track-load request/acknowledge handshake. It keeps elapsed play time and drives the 28-bit, 4-digit seven-segment export with either MM:SS or the track number.

Parameters:
CLK_HZ, 50000000, system clock frequency; sets the 1 s tick period.
DEBOUNCE_MS, 20, required stable time for a button level before it is accepted.
NUM_TRACKS, 8, number of tracks; valid range 2..99.
TRACK_W, 7, width of the track index; must satisfy 2^TRACK_W >= NUM_TRACKS.

Ports:
clk_clk  input  1  system clock
reset_reset_n  input  1  asynchronous active-low reset
buttons_export  input  4  raw KEYs, active-low; [0] play/pause, [1] stop, [2] next, [3] prev
switchs_export  input  3  [0] repeat-all, [1] display select (0 = time, 1 = track), [2] repeat-one
load_req  output  1  request to decoder to load and start load_track
load_track  output  TRACK_W  track index; stable while load_req=1
load_ack  input  1  one-cycle decoder acknowledge of load_req
track_done  input  1  one-cycle pulse: decoder reached end of track
playing  output  1  1 in PLAY state; decoder runs only when high
seven_seg_export  output  28  HEX3..HEX0, 7 bits each, active-low; [6:0] = HEX0 (rightmost)

Behaviour:
- Reset values:
  - state IDLE, track 0, time 00:00, load_req 0, load_track 0, playing 0.
  - seven_seg_export 28'hFFFFFFF (all segments off). It shows valid data from the first clock after reset release.
- Buttons:
  - Each button passes through a 2-FF synchronizer, then a debouncer with DB_CYCLES = CLK_HZ/1000*DEBOUNCE_MS.
  - The debounced level updates only after DB_CYCLES consecutive equal samples.
  - A press event is a one-cycle pulse on the debounced transition to pressed (raw input low). Release generates no event.
- FSM states: IDLE, LOAD, PLAY, PAUSE. At most one event is acted on per cycle.
  - Priority: stop > track_done > next > prev > play. Lower-priority events in the same cycle are dropped.
- IDLE:
  - play → LOAD.
  - next/prev → track ±1 with wrap (NUM_TRACKS-1 ↔ 0); stay in IDLE.
  - stop and track_done are ignored.
- LOAD:
  - load_req=1 and load_track=track, both registered.
  - load_req never drops before load_ack. On load_ack, load_req falls in the next cycle.
  - On load_ack: time cleared to 00:00, then → PLAY. If a stop was pending → IDLE instead.
  - A stop during LOAD sets the pending flag. All other buttons and track_done are ignored in LOAD.
  - load_ack outside LOAD is ignored.
- PLAY:
  - play → PAUSE.
  - stop → IDLE; time cleared; track kept.
  - next → track+1 (wrap) → LOAD.
  - prev: if elapsed >= 00:03, same track → LOAD; otherwise track-1 (wrap) → LOAD.
  - track_done:
    - repeat-one=1 → same track → LOAD.
    - track = NUM_TRACKS-1 and repeat-all=0 → IDLE with track 0.
    - otherwise → track+1 (wrap) → LOAD.
- PAUSE:
  - play → PLAY; stop → IDLE with time cleared.
  - next/prev behave as in PLAY.
  - track_done is ignored.
- Timekeeping:
  - The prescaler counts 0..CLK_HZ-1 only in PLAY. It holds in PAUSE and clears on entry to LOAD or IDLE.
  - At wrap, BCD time increments: sec ones 0-9, sec tens 0-5, min ones 0-9, min tens 0-9.
  - Time saturates at 99:59.
- Display (registered, 1-cycle latency from internal state or switches):
  - sw[1]=0: HEX3..HEX0 show min tens, min ones, sec tens, sec ones.
  - sw[1]=1: HEX3 and HEX2 blank; HEX1/HEX0 show (track+1) in decimal, with HEX1 blank when the value is below 10.
  - Segment map is standard DE-board, active-low.
- Switches are 2-FF synchronized and not debounced.
- Reset asserted mid-handshake drops load_req immediately. The decoder must treat this as an abort.

Decomposition:
- Package mp3_ctrl_pkg holds:
  - the state enum;
  - button index constants (BTN_PLAY=0, BTN_STOP=1, BTN_NEXT=2, BTN_PREV=3);
  - the switch index constants;
  - the 7-segment digit-to-segment encode function, including the blank code 7'h7F.
- One sub-module, button_debounce: synchronizer, debounce counter and press pulse. It is instantiated 4 times.
- FSM, timekeeping and display logic stay in mp3_transport_ctrl.

Test Plan:
- Bench parameters: CLK_HZ=1000, DEBOUNCE_MS=2 (DB_CYCLES=2), NUM_TRACKS=8.
- Reset then release with sw=000 → seven_seg = FFFFFFF during reset; next cycle shows "0000" (HEX0 = 7'h40); playing=0; load_req=0.
- Bounce KEY0 low 1 cycle, high 1, low 5 → exactly one play event; load_req=1 with load_track=0. Ack after 4 cycles → load_req low, playing=1. After 61000 cycles display reads "0101".
- In PLAY at 00:01, press prev → load_track=7 (wrap). At 00:05, press prev → load_track unchanged (restart), time cleared after ack.
- Track 7 with track_done, sw=000 → IDLE, track 0, playing=0. Same with sw[0]=1 → LOAD track 0. With sw[2]=1 → LOAD track 7.
- During LOAD (no ack), press stop and next together → load_req stays high and load_track unchanged. On ack → IDLE, playing never asserts.
- PAUSE holds time at 00:07 for 5000 cycles; sw[1]=1 at track 2 → HEX1 blank, HEX0 = encoding of 3 (7'h30).
